// File: rtl/switch_window_sequencer.sv
// Measurement-cycle controller: gates the A/B edge counters for a window of ticks,
// latches both counts and issues a one-cycle PWM set/reset decision.
module switch_window_sequencer #(
  parameter int CW = 7,
  parameter int WW = 13,
  parameter int DB = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          tick,
  input  logic          start,
  input  logic          cont,
  input  logic [WW-1:0] W,
  input  logic [CW-1:0] A_val,
  input  logic [CW-1:0] B_val,
  output logic          cnt_clr,
  output logic          cnt_en,
  output logic          PWMset,
  output logic          PWMreset,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] A_lat,
  output logic [CW-1:0] B_lat,
  output logic [CW:0]   diff
);

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, LATCH, DECIDE} state_t;

  localparam logic signed [CW:0] DB_POS = (CW+1)'(DB);
  localparam logic signed [CW:0] DB_NEG = -DB_POS;

  state_t        state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [WW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] a_lat_q, a_lat_d;
  logic [CW-1:0] b_lat_q, b_lat_d;
  logic [CW:0]   diff_q, diff_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          cnt_en_q, cnt_en_d;
  logic          pwm_set_q, pwm_set_d;
  logic          pwm_reset_q, pwm_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW:0]   diff_calc;

  assign diff_calc = {1'b0, A_val} - {1'b0, B_val};

  // Outputs are registered on entry to the state that owns them; with en low
  // every register holds, so a pending pulse reappears once en returns.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    tcnt_d      = tcnt_q;
    a_lat_d     = a_lat_q;
    b_lat_d     = b_lat_q;
    diff_d      = diff_q;
    cnt_clr_d   = cnt_clr_q;
    cnt_en_d    = cnt_en_q;
    pwm_set_d   = pwm_set_q;
    pwm_reset_d = pwm_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    if (en) begin
      pwm_set_d   = 1'b0;
      pwm_reset_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_d = CLEAR;
        end
        CLEAR: begin
          win_d   = (W == '0) ? WW'(1) : W;
          tcnt_d  = '0;
          state_d = COUNT;
        end
        COUNT: begin
          if (tick) begin
            if (tcnt_q == win_q - WW'(1)) state_d = LATCH;
            else tcnt_d = tcnt_q + WW'(1);
          end
        end
        LATCH: begin
          a_lat_d     = A_val;
          b_lat_d     = B_val;
          diff_d      = diff_calc;
          pwm_set_d   = $signed(diff_calc) > DB_POS;
          pwm_reset_d = $signed(diff_calc) < DB_NEG;
          done_d      = 1'b1;
          state_d     = DECIDE;
        end
        DECIDE: begin
          state_d = cont ? CLEAR : IDLE;
        end
        default: state_d = IDLE;
      endcase
      cnt_clr_d = (state_d == CLEAR);
      cnt_en_d  = (state_d == COUNT);
      busy_d    = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      tcnt_q      <= '0;
      a_lat_q     <= '0;
      b_lat_q     <= '0;
      diff_q      <= '0;
      cnt_clr_q   <= 1'b0;
      cnt_en_q    <= 1'b0;
      pwm_set_q   <= 1'b0;
      pwm_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      tcnt_q      <= tcnt_d;
      a_lat_q     <= a_lat_d;
      b_lat_q     <= b_lat_d;
      diff_q      <= diff_d;
      cnt_clr_q   <= cnt_clr_d;
      cnt_en_q    <= cnt_en_d;
      pwm_set_q   <= pwm_set_d;
      pwm_reset_q <= pwm_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cnt_clr  = cnt_clr_q & en;
  assign cnt_en   = cnt_en_q & en;
  assign PWMset   = pwm_set_q & en;
  assign PWMreset = pwm_reset_q & en;
  assign done     = done_q & en;
  assign busy     = busy_q;
  assign A_lat    = a_lat_q;
  assign B_lat    = b_lat_q;
  assign diff     = diff_q;

endmodule
